// File: rtl/adc_spi_pkg.sv
// ---------------------------------------------------------------------------
// adc_spi_pkg
//   Shared definitions for the multi-channel ADC serial capture block:
//   - state_e   : frame sequencer states (IDLE -> SHIFT -> GAP -> IDLE)
//   - cnt_width : width of the shared bit/gap counter, clog2 of the larger
//                 of FRAME_BITS and GAP_CYCLES (minimum 1 bit)
// ---------------------------------------------------------------------------
package adc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic int cnt_width(input int frame_bits, input int gap_cycles);
        int m;
        m = (frame_bits > gap_cycles) ? frame_bits : gap_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/adc_spi_multich_capture_if.sv
// ---------------------------------------------------------------------------
// adc_spi_multich_capture_if
//   Valid/ready sample stream leaving the capture block.
//   SAMPLE_DATA  : NUM_CH*FRAME_BITS captured words, channel 0 in the LSBs
//   SAMPLE_VALID : SAMPLE_DATA holds a frame not yet consumed
//   SAMPLE_READY : consumer accepts the frame when VALID & READY
//   modport master : the capture block (drives data/valid)
//   modport slave  : the downstream consumer (drives ready)
// ---------------------------------------------------------------------------
interface adc_spi_multich_capture_if #(
    parameter int NUM_CH     = 2,
    parameter int FRAME_BITS = 16
);
    logic [NUM_CH*FRAME_BITS-1:0] SAMPLE_DATA;
    logic                         SAMPLE_VALID;
    logic                         SAMPLE_READY;

    modport master (
        output SAMPLE_DATA,
        output SAMPLE_VALID,
        input  SAMPLE_READY
    );

    modport slave (
        input  SAMPLE_DATA,
        input  SAMPLE_VALID,
        output SAMPLE_READY
    );
endinterface

// File: rtl/adc_spi_shift_chan.sv
// ---------------------------------------------------------------------------
// adc_spi_shift_chan
//   One FRAME_BITS-wide MSB-first deserialiser for a single ADC SDO line.
//   Ports:
//     clk      : serial clock, rising edge
//     rst_n    : asynchronous active-low reset, clears the partial word
//     shift_en : high during each SHIFT cycle of a frame
//     sdo      : serial data from the ADC
//     word     : current shift register contents (complete after the frame)
// ---------------------------------------------------------------------------
module adc_spi_shift_chan #(
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  shift_en,
    input  logic                  sdo,
    output logic [FRAME_BITS-1:0] word
);

    logic [FRAME_BITS-1:0] shreg_q;
    logic [FRAME_BITS-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (shift_en) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], sdo};
        end
    end

    // NOTE: the shift register is a plain register, not a memory, so it is
    // reset; a reset mid-frame must leave no partial word behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign word = shreg_q;

endmodule

// File: rtl/adc_spi_multich_capture.sv
// ---------------------------------------------------------------------------
// adc_spi_multich_capture
//   Drives one shared SYNC/SDI pair to NUM_CH ADCs and deserialises their
//   SDO lines in parallel. Frames run single-shot (one per START) or
//   back-to-back (CONT_MODE). Each completed frame is loaded into a one-deep
//   output buffer with a valid/ready handshake; overwriting an unconsumed
//   frame raises a sticky OVERRUN flag.
//   Ports:
//     SCLK, RESET_N : clock (rising edge) and async active-low reset
//     ENABLE        : permits new frames to start
//     CONT_MODE     : 1 = continuous frames, 0 = one frame per START
//     START         : single-shot request, looked at in IDLE only
//     CMD_WORD      : word sent MSB first on SDI, latched at frame start
//     SDO[c]        : serial data from channel c
//     SYNC, SDI     : frame sync (low during frame) and command data
//     OVERRUN       : sticky overwrite flag, cleared by CLR_OVERRUN
//     BUSY          : a frame or its gap is in progress
//     FRAME_COUNT   : completed frames, wraps
//     smp           : sample stream (SAMPLE_DATA/VALID/READY)
// ---------------------------------------------------------------------------
module adc_spi_multich_capture
    import adc_spi_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int FRAME_BITS = 16,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic                     SCLK,
    input  logic                     RESET_N,
    input  logic                     ENABLE,
    input  logic                     CONT_MODE,
    input  logic                     START,
    input  logic [FRAME_BITS-1:0]    CMD_WORD,
    input  logic [NUM_CH-1:0]        SDO,
    output logic                     SYNC,
    output logic                     SDI,
    output logic                     OVERRUN,
    input  logic                     CLR_OVERRUN,
    output logic                     BUSY,
    output logic [CNT_W-1:0]         FRAME_COUNT,
    adc_spi_multich_capture_if.master smp
);

    localparam int             CW       = cnt_width(FRAME_BITS, GAP_CYCLES);
    localparam logic [CW-1:0]  LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0]  LAST_GAP = CW'(GAP_CYCLES - 1);
    localparam int             DW       = NUM_CH * FRAME_BITS;

    state_e                state_q,   state_d;
    logic [CW-1:0]         cnt_q,     cnt_d;
    logic [FRAME_BITS-1:0] cmd_q,     cmd_d;
    logic                  sync_q,    sync_d;
    logic                  sdi_q,     sdi_d;
    logic [DW-1:0]         data_q,    data_d;
    logic                  valid_q,   valid_d;
    logic                  overrun_q, overrun_d;
    logic [CNT_W-1:0]      count_q,   count_d;

    logic                  shift_en;
    logic                  load;
    logic                  accept;
    logic                  overwrite;
    logic [DW-1:0]         chan_words;

    // One deserialiser per SDO line; all shift together during SHIFT.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        adc_spi_shift_chan #(
            .FRAME_BITS (FRAME_BITS)
        ) u_chan (
            .clk      (SCLK),
            .rst_n    (RESET_N),
            .shift_en (shift_en),
            .sdo      (SDO[ch]),
            .word     (chan_words[ch*FRAME_BITS +: FRAME_BITS])
        );
    end

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        sync_d    = sync_q;
        sdi_d     = sdi_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        shift_en  = 1'b0;
        load      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                sync_d = 1'b1;
                sdi_d  = 1'b0;
                if (ENABLE && (CONT_MODE || START)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    sync_d  = 1'b0;
                    // SDI is registered, so the MSB goes out on entry and
                    // the rest of the word waits in cmd_q.
                    sdi_d   = CMD_WORD[FRAME_BITS-1];
                    cmd_d   = CMD_WORD << 1;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    sync_d  = 1'b1;
                    sdi_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    sdi_d   = cmd_q[FRAME_BITS-1];
                    cmd_d   = cmd_q << 1;
                end
            end
            ST_GAP: begin
                // Shift registers hold the complete frame from the first
                // gap cycle onward; copy them out then.
                load = (cnt_q == '0);
                if (cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sync_d  = 1'b1;
                sdi_d   = 1'b0;
            end
        endcase

        // Output buffer: a load always wins; the old frame is either taken
        // this same cycle (accept) or lost (overwrite).
        if (load) begin
            data_d  = chan_words;
            valid_d = 1'b1;
            count_d = count_q + 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end

        // Set is applied after clear so a new overrun beats CLR_OVERRUN.
        if (CLR_OVERRUN) begin
            overrun_d = 1'b0;
        end
        if (overwrite) begin
            overrun_d = 1'b1;
        end
    end

    assign accept    = valid_q && smp.SAMPLE_READY;
    assign overwrite = load && valid_q && !smp.SAMPLE_READY;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge SCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            sync_q    <= 1'b1;
            sdi_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            sync_q    <= sync_d;
            sdi_q     <= sdi_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign SYNC             = sync_q;
    assign SDI              = sdi_q;
    assign OVERRUN          = overrun_q;
    assign BUSY             = (state_q != ST_IDLE);
    assign FRAME_COUNT      = count_q;
    assign smp.SAMPLE_DATA  = data_q;
    assign smp.SAMPLE_VALID = valid_q;

endmodule

// File: tb/tb_adc_spi_multich_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_multich_capture
//   Directed bench for adc_spi_multich_capture (NUM_CH=2, FRAME_BITS=16,
//   GAP_CYCLES=4). A small ADC model drives SDO MSB first while SYNC is low,
//   records the SDI bits of each frame and the cycle at which each frame
//   begins. Each scenario task does its own comparisons.
// ---------------------------------------------------------------------------
module tb_adc_spi_multich_capture;

    logic        sclk;
    logic        rst_n;
    logic        enable;
    logic        cont_mode;
    logic        start;
    logic [15:0] cmd_word;
    logic [1:0]  sdo;
    logic        sync;
    logic        sdi;
    logic        overrun;
    logic        clr_overrun;
    logic        busy;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    adc_spi_multich_capture_if #(.NUM_CH(2), .FRAME_BITS(16)) smp_if ();

    adc_spi_multich_capture #(
        .NUM_CH     (2),
        .FRAME_BITS (16),
        .GAP_CYCLES (4),
        .CNT_W      (16)
    ) dut (
        .SCLK        (sclk),
        .RESET_N     (rst_n),
        .ENABLE      (enable),
        .CONT_MODE   (cont_mode),
        .START       (start),
        .CMD_WORD    (cmd_word),
        .SDO         (sdo),
        .SYNC        (sync),
        .SDI         (sdi),
        .OVERRUN     (overrun),
        .CLR_OVERRUN (clr_overrun),
        .BUSY        (busy),
        .FRAME_COUNT (frame_count),
        .smp         (smp_if)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    // ---------------- ADC model ----------------
    logic [15:0] adc_word [2];
    logic [15:0] cur_word [2];
    logic [15:0] sdi_seen;
    int          bit_k;
    int          cyc;
    int          fall_cyc [$];

    initial begin
        sdo      = 2'b00;
        bit_k    = 0;
        cyc      = 0;
        sdi_seen = '0;
        forever begin
            @(posedge sclk);
            #1;
            cyc++;
            if (!rst_n || sync) begin
                bit_k = 0;
                sdo   = 2'b00;
            end else if (bit_k < 16) begin
                if (bit_k == 0) begin
                    cur_word[0] = adc_word[0];
                    cur_word[1] = adc_word[1];
                    fall_cyc.push_back(cyc);
                end
                sdo[0]   = cur_word[0][15-bit_k];
                sdo[1]   = cur_word[1][15-bit_k];
                sdi_seen = {sdi_seen[14:0], sdi};
                bit_k++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge sclk);
        #2;
    endtask

    task automatic do_reset();
        rst_n                 = 1'b0;
        enable                = 1'b0;
        cont_mode             = 1'b0;
        start                 = 1'b0;
        clr_overrun           = 1'b0;
        cmd_word              = '0;
        smp_if.SAMPLE_READY   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_sync(input logic level, input int budget, input string name);
        int n = 0;
        while (sync !== level && n < budget) begin
            tick();
            n++;
        end
        if (sync !== level) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for SYNC=%b", name, level);
        end
    endtask

    task automatic wait_count(input logic [15:0] value, input int budget, input string name);
        int n = 0;
        while (frame_count !== value && n < budget) begin
            tick();
            n++;
        end
        if (frame_count !== value) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, FRAME_COUNT=%0d expected %0d", name, frame_count, value);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout waiting for BUSY=0", name);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; cont_mode = 1'b1; start = 1'b1;
        cmd_word = 16'hFFFF; clr_overrun = 1'b0; smp_if.SAMPLE_READY = 1'b0;
        repeat (2) tick();
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL reset_sync: got %b expected 1", sync); end
        checks++; if (sdi !== 1'b0) begin errors++; $display("FAIL reset_sdi: got %b expected 0", sdi); end
        checks++; if (smp_if.SAMPLE_DATA !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", smp_if.SAMPLE_DATA); end
        checks++; if (smp_if.SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", smp_if.SAMPLE_VALID); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
    endtask

    task automatic test_single_shot();
        int  n;
        logic saw_low;
        do_reset();
        adc_word[0] = 16'hA5C3;
        adc_word[1] = 16'h1234;
        cmd_word    = 16'h8001;
        enable      = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (sync !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ss_frame_start: sync=%b busy=%b expected 0/1", sync, busy); end
        n = 0;
        while (sync === 1'b0 && n < 40) begin
            n++;
            if (n == 4) cmd_word = 16'h7FFE;
            tick();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL ss_sync_low_len: got %0d expected 16", n); end
        checks++; if (smp_if.SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL ss_valid_early: got %b expected 0", smp_if.SAMPLE_VALID); end
        tick();
        checks++; if (smp_if.SAMPLE_VALID !== 1'b1) begin errors++; $display("FAIL ss_valid: got %b expected 1", smp_if.SAMPLE_VALID); end
        checks++; if (smp_if.SAMPLE_DATA !== 32'h1234A5C3) begin errors++; $display("FAIL ss_data: got %h expected 1234a5c3", smp_if.SAMPLE_DATA); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL ss_count: got %0d expected 1", frame_count); end
        checks++; if (sdi_seen !== 16'h8001) begin errors++; $display("FAIL ss_sdi_bits: got %h expected 8001", sdi_seen); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ss_overrun: got %b expected 0", overrun); end
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_idle_after_gap: busy=%b expected 0", busy); end
        saw_low = 1'b0;
        repeat (25) begin
            tick();
            if (sync !== 1'b1) saw_low = 1'b1;
        end
        checks++; if (saw_low !== 1'b0) begin errors++; $display("FAIL ss_no_second_frame: saw SYNC low=%b expected 0", saw_low); end
        checks++; if (smp_if.SAMPLE_VALID !== 1'b1 || smp_if.SAMPLE_DATA !== 32'h1234A5C3) begin errors++; $display("FAIL ss_data_hold: valid=%b data=%h expected 1/1234a5c3", smp_if.SAMPLE_VALID, smp_if.SAMPLE_DATA); end
        smp_if.SAMPLE_READY = 1'b1;
        tick();
        smp_if.SAMPLE_READY = 1'b0;
        checks++; if (smp_if.SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL ss_consume: valid=%b expected 0", smp_if.SAMPLE_VALID); end
    endtask

    task automatic test_continuous();
        do_reset();
        adc_word[0] = 16'h0F0F;
        adc_word[1] = 16'hC3A5;
        fall_cyc.delete();
        smp_if.SAMPLE_READY = 1'b1;
        cont_mode = 1'b1;
        enable    = 1'b1;
        wait_count(16'd3, 120, "cont_three_frames");
        enable = 1'b0;
        wait_idle(40, "cont_idle");
        repeat (30) tick();
        checks++; if (fall_cyc.size() != 3) begin
            errors++; $display("FAIL cont_frame_starts: got %0d expected 3", fall_cyc.size());
        end else begin
            checks++; if (fall_cyc[1] - fall_cyc[0] != 21) begin errors++; $display("FAIL cont_period_1: got %0d expected 21", fall_cyc[1] - fall_cyc[0]); end
            checks++; if (fall_cyc[2] - fall_cyc[1] != 21) begin errors++; $display("FAIL cont_period_2: got %0d expected 21", fall_cyc[2] - fall_cyc[1]); end
        end
        checks++; if (frame_count !== 16'd3) begin errors++; $display("FAIL cont_count: got %0d expected 3", frame_count); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL cont_overrun: got %b expected 0", overrun); end
        checks++; if (smp_if.SAMPLE_DATA !== 32'hC3A50F0F) begin errors++; $display("FAIL cont_data: got %h expected c3a50f0f", smp_if.SAMPLE_DATA); end
        checks++; if (smp_if.SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL cont_valid_consumed: got %b expected 0", smp_if.SAMPLE_VALID); end
        cont_mode = 1'b0;
        smp_if.SAMPLE_READY = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        adc_word[0] = 16'h1111;
        adc_word[1] = 16'h2222;
        cont_mode = 1'b1;
        enable    = 1'b1;
        wait_sync(1'b0, 10, "ovr_frame1_start");
        adc_word[0] = 16'h3333;
        adc_word[1] = 16'h4444;
        wait_count(16'd1, 40, "ovr_frame1");
        checks++; if (smp_if.SAMPLE_DATA !== 32'h22221111 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_frame1: data=%h overrun=%b expected 22221111/0", smp_if.SAMPLE_DATA, overrun); end
        wait_count(16'd2, 40, "ovr_frame2");
        enable = 1'b0;
        checks++; if (smp_if.SAMPLE_DATA !== 32'h44443333) begin errors++; $display("FAIL ovr_data: got %h expected 44443333", smp_if.SAMPLE_DATA); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        checks++; if (smp_if.SAMPLE_VALID !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", smp_if.SAMPLE_VALID); end
        tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        wait_idle(40, "ovr_idle");
        cont_mode = 1'b0;
    endtask

    task automatic test_ready_on_load();
        do_reset();
        adc_word[0] = 16'h0102;
        adc_word[1] = 16'h0304;
        enable = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        wait_count(16'd1, 40, "rol_frame1");
        wait_idle(40, "rol_idle1");
        checks++; if (smp_if.SAMPLE_VALID !== 1'b1) begin errors++; $display("FAIL rol_valid1: got %b expected 1", smp_if.SAMPLE_VALID); end
        adc_word[0] = 16'h0506;
        adc_word[1] = 16'h0708;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sync(1'b1, 40, "rol_frame2_end");
        smp_if.SAMPLE_READY = 1'b1;
        tick();
        checks++; if (smp_if.SAMPLE_VALID !== 1'b1) begin errors++; $display("FAIL rol_valid_stays: got %b expected 1", smp_if.SAMPLE_VALID); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rol_no_overrun: got %b expected 0", overrun); end
        checks++; if (smp_if.SAMPLE_DATA !== 32'h07080506) begin errors++; $display("FAIL rol_data: got %h expected 07080506", smp_if.SAMPLE_DATA); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL rol_count: got %0d expected 2", frame_count); end
        tick();
        smp_if.SAMPLE_READY = 1'b0;
        checks++; if (smp_if.SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL rol_consume: got %b expected 0", smp_if.SAMPLE_VALID); end
        wait_idle(40, "rol_idle2");
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        adc_word[0] = 16'hFFFF;
        adc_word[1] = 16'hFFFF;
        cont_mode = 1'b1;
        enable    = 1'b1;
        wait_count(16'd1, 40, "rmf_frame1");
        wait_sync(1'b0, 40, "rmf_frame2_start");
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (sync !== 1'b1) begin errors++; $display("FAIL rmf_sync: got %b expected 1", sync); end
        checks++; if (smp_if.SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL rmf_valid: got %b expected 0", smp_if.SAMPLE_VALID); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rmf_count: got %0d expected 0", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b expected 0", busy); end
        checks++; if (smp_if.SAMPLE_DATA !== 32'h0) begin errors++; $display("FAIL rmf_data: got %h expected 00000000", smp_if.SAMPLE_DATA); end
        do_reset();
    endtask

    task automatic test_enable_drop();
        int n;
        do_reset();
        adc_word[0] = 16'h5A5A;
        adc_word[1] = 16'h00FF;
        cont_mode = 1'b1;
        enable    = 1'b1;
        wait_sync(1'b0, 10, "ed_frame_start");
        repeat (5) tick();
        enable = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n != 15) begin errors++; $display("FAIL ed_cycles_to_idle: got %0d expected 15", n); end
        repeat (30) tick();
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL ed_count: got %0d expected 1", frame_count); end
        checks++; if (busy !== 1'b0 || sync !== 1'b1) begin errors++; $display("FAIL ed_stays_idle: busy=%b sync=%b expected 0/1", busy, sync); end
        checks++; if (smp_if.SAMPLE_DATA !== 32'h00FF5A5A) begin errors++; $display("FAIL ed_data: got %h expected 00ff5a5a", smp_if.SAMPLE_DATA); end
        cont_mode = 1'b0;
    endtask

    initial begin
        adc_word[0] = '0;
        adc_word[1] = '0;
        test_reset();
        test_single_shot();
        test_continuous();
        test_overrun();
        test_ready_on_load();
        test_reset_mid_frame();
        test_enable_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
